// File: rtl/andor_share_arb.sv
// andor_share_arb: round-robin arbiter time-sharing one bitwise (a & b) | c datapath among NREQ requesters.
// Define ANDOR_SHARE_ARB_STATS_EN to add txn_count, a saturating count of completed transactions.
module andor_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  input  logic [NREQ*WIDTH-1:0] c_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      y_out,
  output logic                  y_valid,
  output logic [IDW-1:0]        y_id
`ifdef ANDOR_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]           txn_count
`endif
);

  // state | meaning
  // IDLE  | waiting for any req; arbitrates and latches the winner's operands
  // EVAL  | gnt visible; evaluates the latched operands into y_out
  // HOLD  | y_valid visible; returns to IDLE
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [WIDTH-1:0]     a_l_q, a_l_d, b_l_q, b_l_d, c_l_q, c_l_d;
  logic [WIDTH-1:0]     y_out_q, y_out_d;
  logic                 y_valid_q, y_valid_d;
  logic [IDW-1:0]       y_id_q, y_id_d;
  logic [IDW-1:0]       win, idx;
  logic                 found;
  logic [WIDTH-1:0]     a_arr [NREQ];
  logic [WIDTH-1:0]     b_arr [NREQ];
  logic [WIDTH-1:0]     c_arr [NREQ];
`ifdef ANDOR_SHARE_ARB_STATS_EN
  logic [15:0]          cnt_q, cnt_d;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = a_in[g*WIDTH +: WIDTH];
    assign b_arr[g] = b_in[g*WIDTH +: WIDTH];
    assign c_arr[g] = c_in[g*WIDTH +: WIDTH];
  end

  // Rotating scan starting at ptr; first set bit wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    a_l_d     = a_l_q;
    b_l_d     = b_l_q;
    c_l_d     = c_l_q;
    y_out_d   = y_out_q;
    y_valid_d = y_valid_q;
    y_id_d    = y_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = NREQ'(1) << win;
          a_l_d   = a_arr[win];
          b_l_d   = b_arr[win];
          c_l_d   = c_arr[win];
          y_id_d  = win;
          ptr_d   = IDW'((int'(win) + 1) % NREQ);
          state_d = EVAL;
        end
      end
      EVAL: begin
        y_out_d   = (a_l_q & b_l_q) | c_l_q;
        y_valid_d = 1'b1;
        gnt_d     = '0;
        state_d   = HOLD;
      end
      HOLD: begin
        y_valid_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ANDOR_SHARE_ARB_STATS_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == EVAL && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      a_l_q     <= '0;
      b_l_q     <= '0;
      c_l_q     <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      y_id_q    <= '0;
`ifdef ANDOR_SHARE_ARB_STATS_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      a_l_q     <= a_l_d;
      b_l_q     <= b_l_d;
      c_l_q     <= c_l_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      y_id_q    <= y_id_d;
`ifdef ANDOR_SHARE_ARB_STATS_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign y_id    = y_id_q;
`ifdef ANDOR_SHARE_ARB_STATS_EN
  assign txn_count = cnt_q;
`endif

endmodule

// File: doc/andor_share_arb.md
Name: andor_share_arb

Overview:
- Round-robin arbiter and sequencer that time-shares one AND-OR evaluation datapath, y = (a & b) | c bitwise, among NREQ requesters.
- Each requester presents an operand triple and a request. The block grants one requester, latches its operands, evaluates the shared AND-OR, and returns a registered result tagged with the requester index.
- Sits between operand-producing agents and the single gate-level AND-OR cell.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- WIDTH, 1, operand and result width; evaluation is bitwise.
- IDW, $clog2(NREQ), width of the requester index (localparam, derived).

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; bit i = requester i.
- a_in  input  NREQ*WIDTH  operand a; slice i = bits [i*WIDTH +: WIDTH].
- b_in  input  NREQ*WIDTH  operand b, same packing.
- c_in  input  NREQ*WIDTH  operand c, same packing.
- gnt  output  NREQ  registered one-hot grant; one-cycle pulse.
- busy  output  1  high in any state other than IDLE.
- y_out  output  WIDTH  registered result (a & b) | c of the granted requester.
- y_valid  output  1  one-cycle pulse qualifying y_out and y_id.
- y_id  output  IDW  index of the requester that owns y_out.

Behaviour:
- Reset: the synchronous rst sample wins over all other activity. Reset values:
  - state = IDLE, gnt = 0, busy = 0, y_out = 0, y_valid = 0, y_id = 0.
  - rr pointer ptr = 0; latched operands = 0.
- FSM states: IDLE, EVAL, HOLD. Each state lasts exactly one cycle except IDLE, which persists while req == 0.
- IDLE, cycle N, req != 0:
  - Winner k = first set bit of req scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - At the edge: gnt <= onehot(k); latch a/b/c slice k; y_id <= k; ptr <= (k+1) mod NREQ; state <= EVAL.
- EVAL, cycle N+1 (gnt visible):
  - At the edge: y_out <= (a_l & b_l) | c_l; y_valid <= 1; gnt <= 0; state <= HOLD.
- HOLD, cycle N+2 (y_valid visible):
  - At the edge: y_valid <= 0; state <= IDLE.
- Latency and throughput:
  - Request sampled in cycle N → gnt in N+1 → result in N+2.
  - Next arbitration in cycle N+3 at the earliest; maximum throughput is one transaction per 3 cycles.
- Handshake:
  - A requester holds req and its operands stable until it sees its gnt bit.
  - It deasserts req no later than cycle N+2 (the cycle y_valid is high).
  - req still high in IDLE is treated as a new request.
- Operand capture: operand changes after cycle N do not affect the result.
- Fairness: a requester holding req continuously is granted within NREQ transactions.
- Ordering: req bits that rise during EVAL or HOLD are not lost; they are evaluated at the next IDLE.
- busy = (state != IDLE); it is combinational from the state register.
- Single requester: only req[k] set, repeatedly → always granted, ptr still advances past k.
- All requesters asserted with ptr = p → grants in order p, p+1, ..., wrapping.
- Reset mid-operation (EVAL or HOLD): the transaction is discarded; no y_valid pulse occurs; ptr returns to 0.

Optional Feature:
- Macro: ANDOR_SHARE_ARB_STATS_EN.
- When defined:
  - Extra output port txn_count, output, 16 bits, counts completed transactions (increments in the cycle y_valid is asserted).
  - Saturates at 16'hFFFF; cleared by rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold rst high 3 cycles with req = 4'b1111 → gnt = 0, y_valid = 0, busy = 0, y_out = 0 throughout; first grant goes to requester 0 two cycles after rst falls.
- Single transaction (WIDTH=1): req = 4'b0100, a2 = 1, b2 = 1, c2 = 0 → gnt = 4'b0100 in N+1, y_valid = 1, y_out = 1, y_id = 2 in N+2. Repeat with a2 = 1, b2 = 0, c2 = 0 → y_out = 0.
- Truth-table sweep on requester 1: all 8 (a, b, c) combinations → y_out matches 0,1,0,1,0,1,1,1 for abc = 000..111.
- Round-robin: req held at 4'b1111 for 12 cycles → grant sequence 0,1,2,3; gnt pulses spaced exactly 3 cycles apart; each y_id matches the preceding gnt index.
- Operand capture and reset abort:
  - Change a_in of the granted requester during EVAL → y_out reflects the value sampled in cycle N.
  - Assert rst during EVAL → no y_valid pulse; next grant restarts from requester 0.
- Stats (with ANDOR_SHARE_ARB_STATS_EN): 5 completed transactions → txn_count = 5; after rst → txn_count = 0.
